kernel_mem_sequencer: RTL and testbench

Sequences the filter memory's kernel-side port during a weighted-order-statistics filter run. On a start command it walks an N×N window across a byte image stored in data memory. For each window it streams the window pixels to the filter core, waits for the filtered result, and writes that result back to a destination image. While it runs it owns the memory's `i_kernel_*` inputs, so the CPU pipeline's memory access is muxed out for the whole run.

---
 rtl/kernel_seq_pkg.sv | 27 ++
 rtl/window_addr_gen.sv | 113 +++++++++++
 rtl/kernel_mem_sequencer.sv | 150 +++++++++++++++
 tb/tb_kernel_mem_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_seq_pkg.sv
// Shared definitions for the kernel-side memory sequencer: state encoding,
// largest kernel size, and the start-parameter check.
package kernel_seq_pkg;

    localparam int MAX_N = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_RES = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // A run needs an odd kernel no larger than the limit that fits inside the image.
    function automatic logic params_ok(
        input logic [2:0]  n,
        input logic [31:0] w,
        input logic [31:0] h,
        input int          max_n
    );
        logic [31:0] n32;
        n32 = {29'd0, n};
        return n[0] && (n32 >= 32'd1) && (n32 <= 32'(max_n)) && (w >= n32) && (h >= n32);
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window address generator: origin counters, in-window row/column counters and
// the incremental row-base / destination address registers.
module window_addr_gen #(
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             advance_pix,
    input  logic             advance_win,
    input  logic [2:0]       n_in,
    input  logic [DIM_W-1:0] width_in,
    input  logic [DIM_W-1:0] height_in,
    input  logic [31:0]      src_in,
    input  logic [31:0]      dst_in,
    output logic [31:0]      rd_next,
    output logic [31:0]      win_next,
    output logic [31:0]      wr_addr,
    output logic             pix_last,
    output logic             win_last
);
    import kernel_seq_pkg::*;

    logic [2:0]       n_q;
    logic [2:0]       i_cnt;
    logic [2:0]       j_cnt;
    logic [DIM_W-1:0] w_q;
    logic [DIM_W-1:0] h_q;
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      win_base;
    logic [31:0]      row_base;
    logic [31:0]      wr_addr_q;

    logic [31:0]      w32;
    logic [31:0]      rd_cur;
    logic [2:0]       n_m1;
    logic [2:0]       r_idx;
    logic             row_end;
    logic             x_last;
    logic             y_last;

    assign w32     = 32'(w_q);
    assign n_m1    = n_q - 3'd1;
    assign r_idx   = n_q >> 1;
    assign row_end = (j_cnt == n_m1);
    assign rd_cur  = row_base + 32'(j_cnt);
    assign rd_next = row_end ? (row_base + w32) : (rd_cur + 32'd1);
    assign x_last  = (x == (w_q - DIM_W'(n_q)));
    assign y_last  = (y == (h_q - DIM_W'(n_q)));
    // Wrapping the row moves the origin from (W-N, y) to (0, y+1), i.e. +N bytes.
    assign win_next = x_last ? (win_base + 32'(n_q)) : (win_base + 32'd1);
    assign pix_last = row_end && (i_cnt == n_m1);
    assign win_last = x_last && y_last;
    assign wr_addr  = wr_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q       <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            w_q       <= '0;
            h_q       <= '0;
            x         <= '0;
            y         <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            win_base  <= '0;
            row_base  <= '0;
            wr_addr_q <= '0;
        end else if (restart) begin
            n_q      <= n_in;
            w_q      <= width_in;
            h_q      <= height_in;
            src_q    <= src_in;
            dst_q    <= dst_in;
            x        <= '0;
            y        <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            win_base <= src_in;
            row_base <= src_in;
        end else begin
            if (advance_pix) begin
                // The centre pixel's source offset is exactly the destination offset.
                if ((i_cnt == r_idx) && (j_cnt == r_idx))
                    wr_addr_q <= dst_q + (rd_cur - src_q);
                if (row_end) begin
                    j_cnt    <= '0;
                    i_cnt    <= i_cnt + 3'd1;
                    row_base <= row_base + w32;
                end else begin
                    j_cnt <= j_cnt + 3'd1;
                end
            end
            if (advance_win) begin
                i_cnt    <= '0;
                j_cnt    <= '0;
                win_base <= win_next;
                row_base <= win_next;
                if (x_last) begin
                    x <= '0;
                    y <= y + DIM_W'(1);
                end else begin
                    x <= x + DIM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/kernel_mem_sequencer.sv
// Drives the filter memory's kernel port during a filter run: streams each
// N x N window to the filter core and writes the returned pixel back.
module kernel_mem_sequencer #(
    parameter int MAX_N = kernel_seq_pkg::MAX_N,
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [2:0]       i_n,
    input  logic [31:0]      i_src_base,
    input  logic [31:0]      i_dst_base,
    input  logic [DIM_W-1:0] i_width,
    input  logic [DIM_W-1:0] i_height,
    input  logic [7:0]       i_mem_data,
    input  logic             i_result_valid,
    input  logic [7:0]       i_result,
    output logic             o_kernel_running,
    output logic [31:0]      o_kernel_address,
    output logic             o_kernel_w_en,
    output logic [7:0]       o_kernel_input,
    output logic             o_pix_valid,
    output logic [7:0]       o_pix_data,
    output logic             o_pix_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);
    import kernel_seq_pkg::*;

    state_t      state;
    logic        start_ok;
    logic        restart;
    logic        adv_pix;
    logic        adv_win;
    logic [31:0] rd_next;
    logic [31:0] win_next;
    logic [31:0] wr_addr;
    logic        fetch_last;
    logic        win_last;

    assign start_ok = params_ok(i_n, 32'(i_width), 32'(i_height), MAX_N);
    assign restart  = (state == ST_IDLE) && i_start && start_ok;
    assign adv_pix  = (state == ST_FETCH) && !i_abort;
    assign adv_win  = (state == ST_WRITE) && !i_abort && !win_last;

    window_addr_gen #(
        .DIM_W(DIM_W)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .advance_pix(adv_pix),
        .advance_win(adv_win),
        .n_in       (i_n),
        .width_in   (i_width),
        .height_in  (i_height),
        .src_in     (i_src_base),
        .dst_in     (i_dst_base),
        .rd_next    (rd_next),
        .win_next   (win_next),
        .wr_addr    (wr_addr),
        .pix_last   (fetch_last),
        .win_last   (win_last)
    );

    // The address register always holds the access for the current cycle, so
    // each transition loads the address the next state will present.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            o_kernel_running <= 1'b0;
            o_kernel_address <= '0;
            o_kernel_w_en    <= 1'b0;
            o_kernel_input   <= '0;
            o_pix_valid      <= 1'b0;
            o_pix_data       <= '0;
            o_pix_last       <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_err            <= 1'b0;
        end else begin
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            o_pix_valid   <= 1'b0;
            o_pix_last    <= 1'b0;
            o_kernel_w_en <= 1'b0;
            if (state == ST_IDLE) begin
                if (i_start) begin
                    if (start_ok) begin
                        state            <= ST_FETCH;
                        o_busy           <= 1'b1;
                        o_kernel_running <= 1'b1;
                        o_kernel_address <= i_src_base;
                    end else begin
                        o_err <= 1'b1;
                    end
                end
            end else if (i_abort) begin
                state            <= ST_IDLE;
                o_busy           <= 1'b0;
                o_kernel_running <= 1'b0;
                o_kernel_address <= '0;
            end else begin
                case (state)
                    ST_FETCH: begin
                        // Read data for this cycle's address arrives before the edge.
                        o_pix_valid <= 1'b1;
                        o_pix_data  <= i_mem_data;
                        o_pix_last  <= fetch_last;
                        if (fetch_last)
                            state <= ST_WAIT_RES;
                        else
                            o_kernel_address <= rd_next;
                    end
                    ST_WAIT_RES: begin
                        if (i_result_valid) begin
                            state            <= ST_WRITE;
                            o_kernel_w_en    <= 1'b1;
                            o_kernel_input   <= i_result;
                            o_kernel_address <= wr_addr;
                        end
                    end
                    ST_WRITE: begin
                        if (win_last) begin
                            state            <= ST_DONE;
                            o_done           <= 1'b1;
                            o_kernel_running <= 1'b0;
                            o_kernel_address <= '0;
                        end else begin
                            state            <= ST_FETCH;
                            o_kernel_address <= win_next;
                        end
                    end
                    ST_DONE: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state            <= ST_IDLE;
                        o_busy           <= 1'b0;
                        o_kernel_running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kernel_mem_sequencer.sv
// Bench for kernel_mem_sequencer: byte memory, max-filter core stub and a
// window-walk reference model checked every cycle.
module tb_kernel_mem_sequencer;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
        logic        last;
    } pix_t;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_abort;
    logic [2:0]  i_n;
    logic [31:0] i_src_base;
    logic [31:0] i_dst_base;
    logic [15:0] i_width;
    logic [15:0] i_height;
    logic [7:0]  i_mem_data;
    logic        i_result_valid;
    logic [7:0]  i_result;
    logic        o_kernel_running;
    logic [31:0] o_kernel_address;
    logic        o_kernel_w_en;
    logic [7:0]  o_kernel_input;
    logic        o_pix_valid;
    logic [7:0]  o_pix_data;
    logic        o_pix_last;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [54:0] outs_all;

    assign outs_all = {o_kernel_running, o_kernel_address, o_kernel_w_en, o_kernel_input,
                       o_pix_valid, o_pix_data, o_pix_last, o_busy, o_done, o_err};

    kernel_mem_sequencer #(.MAX_N(5), .DIM_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_n             (i_n),
        .i_src_base      (i_src_base),
        .i_dst_base      (i_dst_base),
        .i_width         (i_width),
        .i_height        (i_height),
        .i_mem_data      (i_mem_data),
        .i_result_valid  (i_result_valid),
        .i_result        (i_result),
        .o_kernel_running(o_kernel_running),
        .o_kernel_address(o_kernel_address),
        .o_kernel_w_en   (o_kernel_w_en),
        .o_kernel_input  (o_kernel_input),
        .o_pix_valid     (o_pix_valid),
        .o_pix_data      (o_pix_data),
        .o_pix_last      (o_pix_last),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_err           (o_err)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    pix_t        exp_pix[$];
    wr_t         exp_wr[$];
    logic [31:0] act_rd[$];
    logic [31:0] act_wa[$];
    logic [7:0]  act_wd[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, busy_cyc = 0, run_cyc = 0, wr_cnt = 0;
    int last_pix_cyc = 0, last_wr_cyc = 0;
    int stub_delay = 0;
    bit model_on = 1'b0;
    bit junk_en = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: every window in raster order, pixels row-major, result = window max.
    task automatic build_model(input int n, input int w, input int h,
                               input logic [31:0] src, input logic [31:0] dst);
        int r;
        logic [31:0] a;
        logic [7:0] mx;
        r = (n - 1) / 2;
        for (int y = 0; y <= h - n; y++) begin
            for (int x = 0; x <= w - n; x++) begin
                mx = 8'd0;
                for (int i = 0; i < n; i++) begin
                    for (int j = 0; j < n; j++) begin
                        a = src + 32'((y + i) * w + (x + j));
                        if (mem[a[15:0]] > mx) mx = mem[a[15:0]];
                        exp_pix.push_back('{a: a, d: mem[a[15:0]], last: (i == n - 1) && (j == n - 1)});
                    end
                end
                exp_wr.push_back('{a: dst + 32'((y + r) * w + x + r), d: mx});
            end
        end
    endtask

    // Memory samples on the falling edge.
    initial begin
        i_mem_data = 8'd0;
        forever begin
            @(negedge clk);
            if (o_kernel_running && o_kernel_w_en) mem[o_kernel_address[15:0]] = o_kernel_input;
            i_mem_data = mem[o_kernel_address[15:0]];
        end
    end

    // Filter core stub: max over the streamed window, answered after stub_delay cycles.
    initial begin
        logic [7:0] acc, cur, res;
        bit pend;
        int cnt;
        i_result_valid = 1'b0;
        i_result = 8'd0;
        acc = 8'd0; res = 8'd0; pend = 1'b0; cnt = 0;
        forever begin
            @(posedge clk); #1;
            i_result_valid = 1'b0;
            if (!o_busy) begin
                pend = 1'b0;
                acc = 8'd0;
            end else if (o_pix_valid) begin
                cur = (o_pix_data > acc) ? o_pix_data : acc;
                if (o_pix_last) begin
                    pend = 1'b1; cnt = stub_delay; res = cur; acc = 8'd0;
                end else begin
                    acc = cur;
                    if (junk_en && $urandom_range(0, 3) == 0) begin
                        i_result_valid = 1'b1;
                        i_result = 8'($urandom);
                    end
                end
            end
            if (pend) begin
                if (cnt == 0) begin
                    i_result_valid = 1'b1; i_result = res; pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Compare process.
    initial begin
        pix_t p;
        wr_t q;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (o_pix_valid) begin
                act_rd.push_back(prev_addr);
                if (o_pix_last) last_pix_cyc = cyc;
                if (model_on) begin
                    chk_eq("pix_expected", 64'(exp_pix.size() > 0), 64'd1);
                    if (exp_pix.size() > 0) begin
                        p = exp_pix.pop_front();
                        chk_eq("pix_addr", prev_addr, p.a);
                        chk_eq("pix_data", o_pix_data, p.d);
                        chk_eq("pix_last", o_pix_last, p.last);
                    end
                end
            end
            if (o_kernel_w_en) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                act_wa.push_back(o_kernel_address);
                act_wd.push_back(o_kernel_input);
                if (model_on) begin
                    chk_eq("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
                    if (exp_wr.size() > 0) begin
                        q = exp_wr.pop_front();
                        chk_eq("wr_addr", o_kernel_address, q.a);
                        chk_eq("wr_data", o_kernel_input, q.d);
                    end
                end
            end
            if (o_busy || o_kernel_running || o_done) begin
                chk_eq("running_implies_busy", 64'(!o_kernel_running || o_busy), 64'd1);
                chk_eq("wen_implies_running", 64'(!o_kernel_w_en || o_kernel_running), 64'd1);
                chk_eq("done_not_running", 64'(!o_done || (o_busy && !o_kernel_running)), 64'd1);
            end
            if (o_done) done_cnt++;
            if (o_err) err_cnt++;
            if (o_busy) busy_cyc++;
            if (o_kernel_running) run_cyc++;
            prev_addr = o_kernel_address;
        end
    end

    task automatic drive_params(input int n, input int w, input int h,
                                input logic [31:0] src, input logic [31:0] dst);
        i_n = 3'(n); i_width = 16'(w); i_height = 16'(h);
        i_src_base = src; i_dst_base = dst;
    endtask

    task automatic run_job(input int n, input int w, input int h, input logic [31:0] src,
                           input logic [31:0] dst, input int dly, input bit poke, output int cycles);
        int d0, e0;
        exp_pix.delete(); exp_wr.delete();
        act_rd.delete(); act_wa.delete(); act_wd.delete();
        build_model(n, w, h, src, dst);
        stub_delay = dly;
        d0 = done_cnt; e0 = err_cnt;
        model_on = 1'b1;
        drive_params(n, w, h, src, dst);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        cycles = 0;
        while (!o_done && cycles < 5000) begin
            @(posedge clk); #1;
            cycles++;
            i_start = poke && (cycles == 3);
        end
        i_start = 1'b0;
        chk_eq("done_seen", o_done, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_eq("done_count", done_cnt - d0, 1);
        chk_eq("err_count", err_cnt - e0, 0);
        chk_eq("pix_left", exp_pix.size(), 0);
        chk_eq("wr_left", exp_wr.size(), 0);
    endtask

    task automatic reject(input int n, input int w, input int h);
        int e0, b0, r0;
        e0 = err_cnt; b0 = busy_cyc; r0 = run_cyc;
        drive_params(n, w, h, 32'h100, 32'h200);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk_eq("rej_err_now", o_err, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk_eq("rej_err_once", err_cnt - e0, 1);
        chk_eq("rej_busy", busy_cyc - b0, 0);
        chk_eq("rej_mem_access", run_cyc - r0, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cycles, k, d0, w0, n, w, h;
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        drive_params(0, 0, 0, 32'h0, 32'h0);
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_outputs", outs_all, 55'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 3x3 on a 3x3 image: a single window whose max is 0x5A.
        for (int a = 0; a < 9; a++) mem[16'h100 + a] = 8'(8'h20 + a);
        mem[16'h106] = 8'h5A;
        run_job(3, 3, 3, 32'h100, 32'h200, 0, 1'b0, cycles);
        chk_eq("t1_cycles", cycles, 11);
        chk_eq("t1_reads", act_rd.size(), 9);
        for (int a = 0; a < 9 && a < act_rd.size(); a++)
            chk_eq("t1_read_addr", act_rd[a], 32'h100 + 32'(a));
        chk_eq("t1_writes", act_wa.size(), 1);
        if (act_wa.size() > 0) begin
            chk_eq("t1_wr_addr", act_wa[0], 32'h204);
            chk_eq("t1_wr_data", act_wd[0], 8'h5A);
        end

        // 3x3 on a 5x4 image: six windows, row wrap after x=2.
        run_job(3, 5, 4, 32'h3000, 32'h4000, 0, 1'b0, cycles);
        chk_eq("t2_cycles", cycles, 66);
        chk_eq("t2_writes", act_wa.size(), 6);
        begin
            int offs[6] = '{6, 7, 8, 11, 12, 13};
            for (int a = 0; a < 6 && a < act_wa.size(); a++)
                chk_eq("t2_wr_addr", act_wa[a], 32'h4000 + 32'(offs[a]));
        end
        if (act_rd.size() > 27) begin
            chk_eq("t2_win2_first", act_rd[9], 32'h3001);
            chk_eq("t2_win4_first", act_rd[27], 32'h3005);
        end else begin
            chk_eq("t2_read_count", act_rd.size(), 54);
        end

        // N=1 copies each pixel to the same offset.
        for (int a = 0; a < 4; a++) mem[16'h2000 + a] = ~mem[16'h1000 + a];
        run_job(1, 2, 2, 32'h1000, 32'h2000, 0, 1'b0, cycles);
        chk_eq("t3_cycles", cycles, 12);
        chk_eq("t3_writes", act_wa.size(), 4);
        for (int a = 0; a < 4; a++)
            chk_eq("t3_copy", mem[16'h2000 + a], mem[16'h1000 + a]);

        // Rejected starts.
        reject(4, 8, 8);
        reject(7, 8, 8);
        reject(3, 2, 8);

        // Slow filter core plus an ignored start while busy.
        run_job(3, 3, 3, 32'h100, 32'h700, 10, 1'b1, cycles);
        chk_eq("t5_write_gap", last_wr_cyc - last_pix_cyc, 11);
        chk_eq("t5_cycles", cycles, 21);

        // Abort during FETCH.
        model_on = 1'b0;
        d0 = done_cnt; w0 = wr_cnt;
        drive_params(3, 5, 4, 32'h3000, 32'h4800);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        chk_eq("abort_running", o_kernel_running, 1'b0);
        chk_eq("abort_busy", o_busy, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk_eq("abort_no_write", wr_cnt - w0, 0);
        chk_eq("abort_no_done", done_cnt - d0, 0);

        // Reset while writing, then a clean run from the origin.
        stub_delay = 2;
        d0 = done_cnt;
        drive_params(3, 3, 3, 32'h100, 32'h600);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        k = 0;
        while (!o_kernel_w_en && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk_eq("rst_reached_write", o_kernel_w_en, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_eq("rst_outputs", outs_all, 55'd0);
        rst = 1'b0;
        chk_eq("rst_no_done", done_cnt - d0, 0);
        run_job(3, 3, 3, 32'h100, 32'h600, 1, 1'b0, cycles);
        chk_eq("rst_rerun_cycles", cycles, 12);

        // Randomised jobs with spurious result strobes during fetch.
        junk_en = 1'b1;
        for (int t = 0; t < 10; t++) begin
            n = 2 * $urandom_range(0, 2) + 1;
            w = n + $urandom_range(0, 3);
            h = n + $urandom_range(0, 3);
            run_job(n, w, h, 32'h5000 + 32'($urandom_range(0, 255)),
                    32'h9000 + 32'($urandom_range(0, 255)),
                    $urandom_range(0, 3), 1'(($urandom_range(0, 1))), cycles);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
